// File: rtl/router_pkg.sv
// Shared types and constants for the buffered address router.
// Imported by the router RTL and its testbench.
package router_pkg;

  localparam int ROUTER_DROP_CNT_W = 8;
  localparam int ROUTER_MAX_PORTS  = 16;

  typedef logic [$clog2(ROUTER_MAX_PORTS)-1:0] router_port_idx_t;

  function automatic int router_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Single-clock per-port FIFO with occupancy counter.
// The head output is forced to zero whenever the FIFO is empty.
module router_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale words are masked by the empty check.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/buffered_router.sv
// Address-steered router with one buffered output FIFO per port.
// Words to nonexistent ports are accepted, discarded and counted.
module buffered_router
  import router_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_PORTS  = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = router_addr_w(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                din,
  input  logic                                 din_valid,
  output logic                                 din_ready,
  input  logic [ADDR_WIDTH-1:0]                addr,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]                 dout_valid,
  input  logic [NUM_PORTS-1:0]                 dout_ready,
  output logic [ROUTER_DROP_CNT_W-1:0]         drop_cnt
);

  localparam int SLOTS = 2**ADDR_WIDTH;

  logic [SLOTS-1:0]     legal_map;
  logic [SLOTS-1:0]     full_map;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push;
  logic                 legal;
  router_port_idx_t     port;

  assign port      = router_port_idx_t'(addr);
  assign legal     = legal_map[addr];
  assign din_ready = ~legal | ~full_map[addr];

  // Pad the decode tables so every addr value has a defined entry.
  for (genvar s = 0; s < SLOTS; s++) begin : g_map
    if (s < NUM_PORTS) begin : g_real
      assign legal_map[s] = 1'b1;
      assign full_map[s]  = full[s];
    end else begin : g_pad
      assign legal_map[s] = 1'b0;
      assign full_map[s]  = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign push[i] = din_valid & din_ready
                   & (port == router_port_idx_t'(i));
    assign dout_valid[i] = ~empty[i];

    router_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[i]),
      .pop  (dout_ready[i]),
      .din  (din),
      .dout (dout[i]),
      .full (full[i]),
      .empty(empty[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (din_valid & ~legal & ~&drop_cnt) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_buffered_router.sv
// Bench for buffered_router: queue-based reference model with random traffic,
// plus a 3-port instance for the illegal-address path.
module tb_buffered_router;
  import router_pkg::*;

  localparam int N = 4;
  localparam int D = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [W-1:0]        din = '0;
  logic                din_valid = 1'b0;
  logic                din_ready;
  logic [1:0]          addr = '0;
  logic [N-1:0][W-1:0] dout;
  logic [N-1:0]        dout_valid;
  logic [N-1:0]        dout_ready = '0;
  logic [7:0]          drop_cnt;

  logic [W-1:0]        din3 = '0;
  logic                din_valid3 = 1'b0;
  logic                din_ready3;
  logic [1:0]          addr3 = '0;
  logic [2:0][W-1:0]   dout3;
  logic [2:0]          dout_valid3;
  logic [2:0]          dout_ready3 = '0;
  logic [7:0]          drop_cnt3;

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] mq [N][$];

  always #5 clk = ~clk;

  buffered_router #(.DATA_WIDTH(W), .NUM_PORTS(N), .FIFO_DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .addr(addr), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .drop_cnt(drop_cnt)
  );

  buffered_router #(.DATA_WIDTH(W), .NUM_PORTS(3), .FIFO_DEPTH(D)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .din_valid(din_valid3),
    .din_ready(din_ready3), .addr(addr3), .dout(dout3),
    .dout_valid(dout_valid3), .dout_ready(dout_ready3), .drop_cnt(drop_cnt3)
  );

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  function automatic logic [W-1:0] exp_word(input int i);
    if (mq[i].size() == 0) return '0;
    return mq[i][0];
  endfunction

  function automatic logic exp_ready();
    return mq[addr].size() < D;
  endfunction

  // Advance one clock and apply the same transfers to the model.
  task automatic step();
    bit           acc;
    logic [1:0]   a;
    logic [W-1:0] d;
    bit [N-1:0]   pops;
    a   = addr;
    d   = din;
    acc = din_valid && (mq[a].size() < D);
    for (int i = 0; i < N; i++) pops[i] = dout_ready[i] && (mq[i].size() != 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pops[i]) void'(mq[i].pop_front());
    if (acc) mq[a].push_back(d);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) mq[i].delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din = $urandom; din_valid = 1'b1; addr = 2'($urandom);
    dout_ready = 4'($urandom);
    din3 = $urandom; din_valid3 = 1'b1; addr3 = 2'd3;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    din_valid = 1'b0; addr = '0; dout_ready = '0;
    din_valid3 = 1'b0; addr3 = '0;
    clear_model();
    @(posedge clk);
    #1;
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fails++; $display("FAIL reset_din_ready: got %b want 1", din_ready);
    end
    n_checks++;
    if (dout_valid !== 4'b0000) begin
      n_fails++; $display("FAIL reset_dout_valid: got %b want 0000", dout_valid);
    end
    n_checks++;
    if (dout !== '0) begin
      n_fails++; $display("FAIL reset_dout: got %h want 0", dout);
    end
    n_checks++;
    if (drop_cnt !== 8'd0 || drop_cnt3 !== 8'd0) begin
      n_fails++;
      $display("FAIL reset_drop_cnt: got %0d/%0d want 0/0", drop_cnt, drop_cnt3);
    end
  endtask

  task automatic test_single_route();
    dout_ready = '0;
    din = 32'hDEADBEEF; addr = 2'd2; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    n_checks++;
    if (dout_valid !== 4'b0100) begin
      n_fails++; $display("FAIL single_valid: got %b want 0100", dout_valid);
    end
    n_checks++;
    if (dout[2] !== 32'hDEADBEEF) begin
      n_fails++; $display("FAIL single_data: got %h want deadbeef", dout[2]);
    end
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        n_checks++;
        if (dout[i] !== '0) begin
          n_fails++; $display("FAIL single_zero%0d: got %h want 0", i, dout[i]);
        end
      end
    end
    dout_ready = 4'b0100;
    step();
    dout_ready = '0;
    n_checks++;
    if (dout_valid !== 4'b0000 || dout[2] !== '0) begin
      n_fails++;
      $display("FAIL single_pop: got %b/%h want 0000/0", dout_valid, dout[2]);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] sent [5];
    dout_ready = '0;
    addr = 2'd1;
    for (int k = 0; k < 5; k++) begin
      sent[k] = $urandom;
      din = sent[k]; din_valid = 1'b1;
      #1;
      n_checks++;
      if (din_ready !== (k < 4)) begin
        n_fails++;
        $display("FAIL fill_ready%0d: got %b want %b", k, din_ready, k < 4);
      end
      step();
    end
    din_valid = 1'b0;
    dout_ready = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dout_valid[1] !== 1'b1 || dout[1] !== sent[k]) begin
        n_fails++;
        $display("FAIL fill_order%0d: got %b/%h want 1/%h",
                 k, dout_valid[1], dout[1], sent[k]);
      end
      step();
    end
    dout_ready = '0;
    #1;
    n_checks++;
    if (dout_valid !== 4'b0000 || din_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL fill_drained: got %b/%b want 0000/1", dout_valid, din_ready);
    end
  endtask

  task automatic test_full_pop();
    logic [W-1:0] w [5];
    dout_ready = '0;
    addr = 2'd0;
    for (int k = 0; k < 5; k++) w[k] = $urandom;
    for (int k = 0; k < 4; k++) begin
      din = w[k]; din_valid = 1'b1;
      step();
    end
    din = w[4]; din_valid = 1'b1; dout_ready = 4'b0001;
    #1;
    n_checks++;
    if (din_ready !== 1'b0) begin
      n_fails++; $display("FAIL fullpop_ready: got %b want 0", din_ready);
    end
    step();
    dout_ready = '0;
    #1;
    n_checks++;
    if (dout[0] !== w[1] || din_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL fullpop_after: got %h/%b want %h/1", dout[0], din_ready, w[1]);
    end
    step();
    din_valid = 1'b0;
    dout_ready = 4'b0001;
    for (int k = 1; k < 5; k++) begin
      n_checks++;
      if (dout_valid[0] !== 1'b1 || dout[0] !== w[k]) begin
        n_fails++;
        $display("FAIL fullpop_order%0d: got %b/%h want 1/%h",
                 k, dout_valid[0], dout[0], w[k]);
      end
      step();
    end
    dout_ready = '0;
    n_checks++;
    if (dout_valid !== 4'b0000) begin
      n_fails++; $display("FAIL fullpop_empty: got %b want 0000", dout_valid);
    end
  endtask

  task automatic test_illegal();
    int want;
    addr3 = 2'd3;
    for (int k = 0; k < 300; k++) begin
      din3 = $urandom; din_valid3 = 1'b1; dout_ready3 = 3'($urandom);
      #1;
      n_checks++;
      if (din_ready3 !== 1'b1) begin
        n_fails++; $display("FAIL illegal_ready%0d: got %b want 1", k, din_ready3);
      end
      @(posedge clk);
      #1;
      want = (k + 1 > 255) ? 255 : k + 1;
      n_checks++;
      if (dout_valid3 !== 3'b000 || drop_cnt3 !== 8'(want)) begin
        n_fails++;
        $display("FAIL illegal_drop%0d: got %b/%0d want 000/%0d",
                 k, dout_valid3, drop_cnt3, want);
      end
    end
    din_valid3 = 1'b0; dout_ready3 = '0; addr3 = '0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    dout_ready = '0;
    for (int k = 0; k < 4; k++) begin
      addr = (k % 2 == 0) ? 2'd0 : 2'd3;
      din = $urandom; din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0; addr = '0;
    n_checks++;
    if (dout_valid !== 4'b1001) begin
      n_fails++; $display("FAIL midrst_pre: got %b want 1001", dout_valid);
    end
    #3 rst = 1'b0;
    #1;
    clear_model();
    n_checks++;
    if (dout_valid !== 4'b0000 || dout !== '0 || drop_cnt3 !== 8'd0) begin
      n_fails++;
      $display("FAIL midrst_async: got %b/%h/%0d want 0000/0/0",
               dout_valid, dout, drop_cnt3);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (dout_valid !== 4'b0000 || din_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL midrst_release: got %b/%b want 0000/1", dout_valid, din_ready);
    end
    w = $urandom;
    din = w; addr = 2'd3; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    n_checks++;
    if (dout_valid !== 4'b1000 || dout[3] !== w) begin
      n_fails++;
      $display("FAIL midrst_reuse: got %b/%h want 1000/%h", dout_valid, dout[3], w);
    end
    dout_ready = 4'b1000;
    step();
    dout_ready = '0;
  endtask

  task automatic test_random();
    router_port_idx_t p;
    bit               bad;
    for (int k = 0; k < 600; k++) begin
      p = router_port_idx_t'($urandom_range(0, N - 1));
      addr = p[1:0];
      din = $urandom;
      din_valid = ($urandom % 4) != 0;
      dout_ready = 4'($urandom & $urandom);
      #1;
      n_checks++;
      if (din_ready !== exp_ready()) begin
        n_fails++;
        $display("FAIL rand_ready%0d: got %b want %b", k, din_ready, exp_ready());
      end
      step();
      bad = (dout_valid !== exp_valid());
      for (int i = 0; i < N; i++) if (dout[i] !== exp_word(i)) bad = 1'b1;
      n_checks++;
      if (bad) begin
        n_fails++;
        $display("FAIL rand_out%0d: got %b/%h want %b/%h/%h/%h/%h", k,
                 dout_valid, dout, exp_valid(),
                 exp_word(3), exp_word(2), exp_word(1), exp_word(0));
      end
    end
    din_valid = 1'b0; dout_ready = '0;
    n_checks++;
    if (drop_cnt !== 8'd0) begin
      n_fails++; $display("FAIL rand_drop: got %0d want 0", drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_fill();
    test_full_pop();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
